// File: rtl/jtag_bscan_multi.sv
// IEEE 1149.1 TAP controller with BYPASS/IDCODE registers and NUM_USER
// externally implemented user scan chains, each selected by its own IR code.
module jtag_bscan_multi #(
  parameter int          IR_WIDTH   = 5,
  parameter int          NUM_USER   = 4,
  parameter int          USER_BASE  = 2,
  parameter int          IDCODE_IR  = 9,
  parameter logic [31:0] IDCODE_VAL = 32'h0061_8093
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  input  logic [NUM_USER-1:0] TDO_USER,
  output logic                TDO,
  output logic                TDO_EN,
  output logic                BTDI,
  output logic [NUM_USER-1:0] SEL,
  output logic [NUM_USER-1:0] DRCK_EN,
  output logic                CAPTURE,
  output logic                SHIFT,
  output logic                UPDATE,
  output logic                RESET,
  output logic                RTI,
  output logic [IR_WIDTH-1:0] IR_OUT
);

  if (IR_WIDTH < 4 || IR_WIDTH > 8) begin : g_err_irw
    $error("jtag_bscan_multi: IR_WIDTH out of range 4..8");
  end
  if (NUM_USER < 1 || NUM_USER > 8) begin : g_err_nu
    $error("jtag_bscan_multi: NUM_USER out of range 1..8");
  end
  if (USER_BASE + NUM_USER - 1 >= (1 << IR_WIDTH) - 1) begin : g_err_range
    $error("jtag_bscan_multi: user codes collide with BYPASS or overflow IR");
  end
  if (IDCODE_IR >= USER_BASE && IDCODE_IR <= USER_BASE + NUM_USER - 1) begin : g_err_idu
    $error("jtag_bscan_multi: IDCODE_IR inside user code range");
  end
  if (IDCODE_IR == (1 << IR_WIDTH) - 1) begin : g_err_idb
    $error("jtag_bscan_multi: IDCODE_IR equals BYPASS code");
  end

  localparam logic [IR_WIDTH-1:0] IDC    = IR_WIDTH'(IDCODE_IR);
  localparam logic [IR_WIDTH-1:0] IR_CAP = {{(IR_WIDTH-2){1'b0}}, 2'b01};

  typedef enum logic [3:0] {
    ST_TLR, ST_RTI, ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PAU_DR, ST_EX2_DR,
    ST_UPD_DR, ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PAU_IR, ST_EX2_IR, ST_UPD_IR
  } tap_e;

  tap_e                state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] irsr_q, irsr_d;
  logic                byp_q, byp_d;
  logic [31:0]         id_q, id_d;

  logic [NUM_USER-1:0] sel;
  logic                is_user, is_id, is_byp;

  for (genvar k = 0; k < NUM_USER; k++) begin : g_sel
    assign sel[k] = (ir_q == IR_WIDTH'(USER_BASE + k));
  end

  // Any code that is neither a user channel nor IDCODE falls back to BYPASS.
  assign is_user = |sel;
  assign is_id   = (ir_q == IDC);
  assign is_byp  = !is_user && !is_id;

  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q <= ST_TLR;
      ir_q    <= IDC;
      irsr_q  <= IDC;
      byp_q   <= 1'b0;
      id_q    <= IDCODE_VAL;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      irsr_q  <= irsr_d;
      byp_q   <= byp_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_TLR:    state_d = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:    state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_d = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_d = TMS ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: state_d = TMS ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: state_d = TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_d = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_d = TMS ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: state_d = TMS ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: state_d = TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_d = TMS ? ST_SEL_DR : ST_RTI;
      default:   state_d = ST_TLR;
    endcase
  end

  always_comb begin
    ir_d   = ir_q;
    irsr_d = irsr_q;
    byp_d  = byp_q;
    id_d   = id_q;
    unique case (state_q)
      ST_CAP_IR: irsr_d = IR_CAP;
      ST_SH_IR:  irsr_d = {TDI, irsr_q[IR_WIDTH-1:1]};
      ST_UPD_IR: ir_d   = irsr_q;
      ST_CAP_DR: begin
        if (is_id)       id_d  = IDCODE_VAL;
        else if (is_byp) byp_d = 1'b0;
      end
      ST_SH_DR: begin
        if (is_id)       id_d  = {TDI, id_q[31:1]};
        else if (is_byp) byp_d = TDI;
      end
      default: ;
    endcase
    // Load IDCODE on entry so the IR already reads IDCODE_IR in the first TLR cycle.
    if (state_d == ST_TLR) ir_d = IDC;
  end

  always_comb begin
    TDO = 1'b0;
    if (state_q == ST_SH_IR) begin
      TDO = irsr_q[0];
    end else if (state_q == ST_SH_DR) begin
      if (is_user)    TDO = |(sel & TDO_USER);
      else if (is_id) TDO = id_q[0];
      else            TDO = byp_q;
    end
  end

  assign TDO_EN  = (state_q == ST_SH_IR) || (state_q == ST_SH_DR);
  assign BTDI    = TDI;
  assign SEL     = sel;
  assign CAPTURE = (state_q == ST_CAP_DR);
  assign SHIFT   = (state_q == ST_SH_DR);
  assign UPDATE  = (state_q == ST_UPD_DR);
  assign RESET   = (state_q == ST_TLR);
  assign RTI     = (state_q == ST_RTI);
  assign DRCK_EN = sel & {NUM_USER{CAPTURE | SHIFT}};
  assign IR_OUT  = ir_q;

endmodule

// File: doc/jtag_bscan_multi.md
JTAG_BSCAN_MULTI -- requirements
Module: jtag_bscan_multi

Interface
REQ-001 SHALL provide parameter IR_WIDTH, default 5: instruction register width, legal range 4..8.
REQ-002 SHALL provide parameter NUM_USER, default 4: number of user scan channels, legal range 1..8.
REQ-003 SHALL provide parameter USER_BASE, default 2: IR code of user channel 0; channel k uses USER_BASE+k.
REQ-004 SHALL provide parameter IDCODE_IR, default 9: IR code selecting the IDCODE register.
REQ-005 SHALL provide parameter IDCODE_VAL, default 32'h0061_8093: 32-bit device identification value.
REQ-006 SHALL provide one clock and a synchronous, active-high reset:
- TCK  in  1  single clock; all state updates on the rising edge.
- TRST  in  1  synchronous active-high reset, sampled on the rising edge of TCK.
REQ-007 SHALL provide the remaining ports:
- TMS  in  1  TAP mode select.
- TDI  in  1  serial data in.
- TDO_USER  in  NUM_USER  per-channel user DR serial output.
- TDO  out  1  serial data out.
- TDO_EN  out  1  TDO valid/drive enable.
- BTDI  out  1  equal to TDI.
- SEL  out  NUM_USER  one-hot user channel select.
- DRCK_EN  out  NUM_USER  per-channel capture/shift qualifier.
- CAPTURE, SHIFT, UPDATE  out  1 each  asserted in Capture-DR, Shift-DR, Update-DR respectively.
- RESET  out  1  asserted in Test-Logic-Reset.
- RTI  out  1  asserted in Run-Test/Idle.
- IR_OUT  out  IR_WIDTH  active instruction.
REQ-008 Elaboration SHALL fail on any of:
- USER_BASE+NUM_USER-1 >= 2^IR_WIDTH-1;
- IDCODE_IR within the user code range;
- IDCODE_IR equal to all-ones.

Function
REQ-009 The TAP FSM SHALL implement all 16 IEEE 1149.1 states and transitions, advancing on each rising TCK edge from the sampled TMS.
REQ-010 From any state, five consecutive TMS=1 samples SHALL reach Test-Logic-Reset.
REQ-011 In Test-Logic-Reset, the active IR SHALL hold IDCODE_IR.
REQ-012 Capture-IR SHALL load the IR shift register with {zeros, 2'b01}.
REQ-013 Each Shift-IR cycle SHALL shift the IR shift register right one bit, with TDI entering the MSB.
REQ-014 Update-IR SHALL copy the IR shift register to the active IR; the active IR SHALL change at no other time except reset.
REQ-015 SEL[k] SHALL be 1 iff active IR == USER_BASE+k; all SEL bits SHALL be 0 otherwise.
REQ-016 Instruction decode:
- all-ones selects the 1-bit BYPASS register;
- IDCODE_IR selects the 32-bit IDCODE register;
- any other code outside the user range SHALL behave as BYPASS.
REQ-017 In Capture-DR, BYPASS SHALL load 0 and IDCODE SHALL load IDCODE_VAL.
REQ-018 In Shift-DR, the selected internal DR SHALL shift right with TDI entering the MSB.
REQ-019 User channels SHALL hold no internal DR; user data SHALL come only from TDO_USER.
REQ-020 TDO SHALL be combinational from the current state:
- Shift-IR: IR shift[0];
- Shift-DR with BYPASS or IDCODE selected: that register's bit 0;
- Shift-DR with user k selected: TDO_USER[k];
- otherwise: 0.
REQ-021 TDO_EN SHALL be 1 exactly in Shift-IR and Shift-DR.
REQ-022 DRCK_EN[k] SHALL equal SEL[k] & (Capture-DR | Shift-DR).
REQ-023 CAPTURE, SHIFT, UPDATE, RESET and RTI SHALL be combinational decodes of the current FSM state, with no added latency.
REQ-024 An IR change SHALL take effect on SEL and IR_OUT in the cycle following Update-IR.
REQ-025 A DR scan SHALL NOT disturb the active IR or SEL.
REQ-026 Exit1/Pause/Exit2 states SHALL hold all shift registers unchanged.
REQ-027 TMS=1 while in Test-Logic-Reset SHALL keep the FSM there; RESET SHALL remain 1.

Reset
REQ-028 TRST=1 at a rising TCK edge SHALL force, on that edge:
- FSM to Test-Logic-Reset;
- active IR and IR shift register to IDCODE_IR;
- BYPASS register to 0;
- IDCODE register to IDCODE_VAL.
REQ-029 TRST SHALL override TMS and any scan in progress, including mid-Shift-DR and mid-Update-IR.
REQ-030 During and after reset, outputs SHALL read:
- SEL=0, DRCK_EN=0, TDO=0, TDO_EN=0;
- RESET=1;
- CAPTURE=SHIFT=UPDATE=RTI=0;
- IR_OUT=IDCODE_IR.

Verification
REQ-031 Reset, then shift 32 DR bits with no IR scan -> TDO sequence LSB-first equals IDCODE_VAL (0x00618093 default).
REQ-032 Load IR=5'b00011 (user 1), then run a DR scan:
- SEL=4'b0010;
- DRCK_EN[1]=1 only in Capture-DR/Shift-DR;
- TDO follows TDO_USER[1] each Shift-DR cycle.
REQ-033 Shift-IR with TDI=1 for all 5 bits (BYPASS) -> TDO during Shift-IR yields captured 1,0,0,0,0; then DR shift of 1,0,1,1 gives TDO 0,1,0,1 (one-cycle delay).
REQ-034 Load IR=5'd20 (unused) -> SEL=0; DR path behaves as BYPASS.
REQ-035 Assert TRST for one cycle midway through a user-channel Shift-DR -> next cycle shows:
- RESET=1, SEL=0, TDO_EN=0, IR_OUT=9.
REQ-036 From Shift-DR, drive TMS=1 for 5 cycles -> FSM reaches Test-Logic-Reset with IR_OUT=9.
